// File: rtl/fpmult_pkg.sv
// ============================================================================
// Module  : fpmult_pkg
// Brief   : Shared FSM state type and rounding-mode constants for fpmult.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fpmult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int c_round_trunc     = 0;
  localparam int c_round_half_away = 1;

endpackage

`default_nettype wire

// File: rtl/fpmult_round_sat.sv
// ============================================================================
// Module  : fpmult_round_sat
// Brief   : Scales the unsigned product magnitude, rounds and saturates.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fpmult_round_sat
  import fpmult_pkg::*;
#(
  parameter int n     = 32,
  parameter int d     = 16,
  parameter int ROUND = c_round_trunc
) (
  input  logic [2*n-1:0] i_acc,
  input  logic           i_sign,
  output logic [n-1:0]   o_msg,
  output logic           o_ovf
);

  // One extra bit so the rounding increment can never wrap the magnitude.
  localparam int c_mw = 2*n + 1;
  localparam logic [c_mw-1:0] c_pos_max = {{(c_mw-n+1){1'b0}}, {(n-1){1'b1}}};
  localparam logic [c_mw-1:0] c_neg_max = c_pos_max + c_mw'(1);

  logic [c_mw-1:0] w_sum;
  logic [c_mw-1:0] w_mag;

  generate
    if (ROUND == c_round_half_away && d > 0) begin : g_round
      assign w_sum = {1'b0, i_acc} + (c_mw'(1) << (d-1));
    end else begin : g_trunc
      assign w_sum = {1'b0, i_acc};
    end
  endgenerate

  assign w_mag = w_sum >> d;

  always_comb begin
    o_ovf = 1'b0;
    o_msg = w_mag[n-1:0];
    if (!i_sign) begin
      if (w_mag > c_pos_max) begin
        o_ovf = 1'b1;
        o_msg = {1'b0, {(n-1){1'b1}}};
      end
    end else begin
      if (w_mag > c_neg_max) begin
        o_ovf = 1'b1;
        o_msg = {1'b1, {(n-1){1'b0}}};
      end else begin
        o_msg = -w_mag[n-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fpmult_multibit.sv
// ============================================================================
// Module  : fpmult_multibit
// Brief   : Signed fixed-point multiplier retiring k multiplier bits per cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fpmult_multibit
  import fpmult_pkg::*;
#(
  parameter int n     = 32,
  parameter int d     = 16,
  parameter int k     = 2,
  parameter int ROUND = c_round_trunc
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           recv_val,
  output logic           recv_rdy,
  input  logic [2*n-1:0] recv_msg,
  output logic           send_val,
  input  logic           send_rdy,
  output logic [n-1:0]   send_msg,
  output logic           send_ovf
);

  localparam int c_steps = n / k;
  localparam int c_cw    = $clog2(c_steps) + 1;

  state_t          r_state;
  state_t          w_state_next;
  logic [n-1:0]    r_a_mag;
  logic [n-1:0]    r_b_rem;
  logic            r_sign;
  logic [2*n-1:0]  r_acc;
  logic [c_cw-1:0] r_cnt;
  logic [n-1:0]    r_msg;
  logic            r_ovf;

  logic [n-1:0]    w_a;
  logic [n-1:0]    w_b;
  logic [n-1:0]    w_a_mag;
  logic [n-1:0]    w_b_mag;
  logic [n-1:0]    w_b_next;
  logic            w_last;
  logic [2*n-1:0]  w_partial;
  logic [n-1:0]    w_res;
  logic            w_res_ovf;

  assign w_a      = recv_msg[2*n-1:n];
  assign w_b      = recv_msg[n-1:0];
  // Negating -2^(n-1) yields 2^(n-1), which is exact as an unsigned n-bit value.
  assign w_a_mag  = w_a[n-1] ? -w_a : w_a;
  assign w_b_mag  = w_b[n-1] ? -w_b : w_b;
  assign w_b_next = r_b_rem >> k;
  assign w_last   = (r_cnt == c_cw'(c_steps - 1)) || (w_b_next == '0);

  assign w_partial = ({{n{1'b0}}, r_a_mag} << (k * r_cnt))
                   * {{(2*n-k){1'b0}}, r_b_rem[k-1:0]};

  fpmult_round_sat #(
    .n     (n),
    .d     (d),
    .ROUND (ROUND)
  ) u_round_sat (
    .i_acc  (r_acc),
    .i_sign (r_sign),
    .o_msg  (w_res),
    .o_ovf  (w_res_ovf)
  );

  always_comb begin
    w_state_next = r_state;
    recv_rdy     = 1'b0;
    send_val     = 1'b0;
    case (r_state)
      IDLE: begin
        recv_rdy = 1'b1;
        if (recv_val) w_state_next = CALC;
      end
      CALC: if (w_last) w_state_next = FIN;
      FIN:  w_state_next = DONE;
      DONE: begin
        send_val = 1'b1;
        if (send_rdy) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_a_mag <= '0;
      r_b_rem <= '0;
      r_sign  <= 1'b0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_msg   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: if (recv_val) begin
          r_a_mag <= w_a_mag;
          r_b_rem <= w_b_mag;
          r_sign  <= w_a[n-1] ^ w_b[n-1];
          r_acc   <= '0;
          r_cnt   <= '0;
        end
        CALC: begin
          r_acc   <= r_acc + w_partial;
          r_b_rem <= w_b_next;
          r_cnt   <= r_cnt + c_cw'(1);
        end
        FIN: begin
          r_msg <= w_res;
          r_ovf <= w_res_ovf;
        end
        default: ;
      endcase
    end
  end

  assign send_msg = r_msg;
  assign send_ovf = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_fpmult_multibit.sv
// ============================================================================
// Module  : tb_fpmult_multibit
// Brief   : Scoreboard bench over five parameter sets against a value model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fpmult_multibit;

  localparam int NI = 5;
  localparam int NP [NI] = '{8, 8, 16, 32, 8};
  localparam int DP [NI] = '{4, 4,  8, 16, 0};
  localparam int KP [NI] = '{2, 2,  4,  1, 4};
  localparam int RP [NI] = '{0, 1,  0,  0, 1};

  typedef struct {
    logic [31:0] msg;
    logic        ovf;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        recv_val [NI];
  logic        recv_rdy [NI];
  logic [63:0] recv_msg [NI];
  logic        send_val [NI];
  logic        send_rdy [NI];
  logic [31:0] send_msg [NI];
  logic        send_ovf [NI];

  exp_t sbq [NI][$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [NP[g]-1:0] w_msg;
    exp_t             e_mon;

    fpmult_multibit #(
      .n     (NP[g]),
      .d     (DP[g]),
      .k     (KP[g]),
      .ROUND (RP[g])
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .recv_val (recv_val[g]),
      .recv_rdy (recv_rdy[g]),
      .recv_msg (recv_msg[g][2*NP[g]-1:0]),
      .send_val (send_val[g]),
      .send_rdy (send_rdy[g]),
      .send_msg (w_msg),
      .send_ovf (send_ovf[g])
    );

    assign send_msg[g] = 32'(w_msg);

    always @(negedge clk) begin
      if (!reset && send_val[g] && send_rdy[g]) begin
        if (sbq[g].size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_out[%0d]: got msg=%0h with empty queue", g, send_msg[g]);
        end else begin
          e_mon = sbq[g].pop_front();
          chk($sformatf("data[%0d]", g), {31'd0, send_ovf[g], send_msg[g]},
              {31'd0, e_mon.ovf, e_mon.msg});
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  // Reference: plain signed arithmetic on the interpreted operand values.
  function automatic exp_t ref_model(input int idx, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint mask, sa, sb, ma, mb, p, m, pmax, c, t;
    int     bl, cyc;
    bit     neg, ovf;
    mask = (longint'(1) << NP[idx]) - 1;
    sa   = longint'({32'd0, a}) & mask;
    sb   = longint'({32'd0, b}) & mask;
    if (sa >= (longint'(1) << (NP[idx]-1))) sa = sa - (longint'(1) << NP[idx]);
    if (sb >= (longint'(1) << (NP[idx]-1))) sb = sb - (longint'(1) << NP[idx]);
    ma   = (sa < 0) ? -sa : sa;
    mb   = (sb < 0) ? -sb : sb;
    neg  = (sa < 0) != (sb < 0);
    p    = ma * mb;
    if (RP[idx] == 1 && DP[idx] > 0) p = p + (longint'(1) << (DP[idx]-1));
    m    = p >> DP[idx];
    pmax = (longint'(1) << (NP[idx]-1)) - 1;
    if (!neg) begin
      ovf = m > pmax;
      c   = ovf ? pmax : m;
    end else begin
      ovf = m > pmax + 1;
      c   = ovf ? -(pmax + 1) : -m;
    end
    e.msg = 32'(c & mask);
    e.ovf = ovf;
    bl = 0;
    t  = mb;
    while (t != 0) begin
      bl++;
      t = t >> 1;
    end
    cyc = (bl + KP[idx] - 1) / KP[idx];
    if (cyc < 1) cyc = 1;
    e.lat = cyc + 1;
    return e;
  endfunction

  function automatic logic [63:0] pack(input int idx, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] mask;
    mask = (64'd1 << NP[idx]) - 64'd1;
    return ((({32'd0, a}) & mask) << NP[idx]) | ({32'd0, b} & mask);
  endfunction

  task automatic wait_send(input int idx, output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!send_val[idx] && lat < 100);
  endtask

  task automatic run_txn(input int idx, input logic [31:0] a, input logic [31:0] b, input int hold);
    exp_t e;
    int   lat;
    e = ref_model(idx, a, b);
    chk($sformatf("idle_rdy[%0d]", idx), {63'd0, recv_rdy[idx]}, 64'd1);
    sbq[idx].push_back(e);
    recv_val[idx] = 1'b1;
    recv_msg[idx] = pack(idx, a, b);
    send_rdy[idx] = (hold == 0);
    @(posedge clk);
    #1;
    recv_val[idx] = 1'b0;
    recv_msg[idx] = {$urandom, $urandom};
    wait_send(idx, lat);
    chk($sformatf("latency[%0d] a=%0h b=%0h", idx, a, b), 64'(lat), 64'(e.lat));
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      send_rdy[idx] = 1'b1;
    end
    @(posedge clk);
    #1;
    chk($sformatf("back_idle[%0d]", idx), {62'd0, recv_rdy[idx], send_val[idx]}, 64'd2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    exp_t        e;
    int          lat;
    logic [31:0] a, b, msk;
    reset = 1'b1;
    for (int i = 0; i < NI; i++) begin
      recv_val[i] = 1'b0;
      recv_msg[i] = '0;
      send_rdy[i] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_ctl[%0d]", i), {62'd0, recv_rdy[i], send_val[i]}, 64'd2);
      chk($sformatf("rst_out[%0d]", i), {31'd0, send_ovf[i], send_msg[i]}, 64'd0);
    end
    reset = 1'b0;

    run_txn(0, 32'h18, 32'h28, 0);
    run_txn(0, 32'hE8, 32'h28, 0);
    run_txn(0, 32'h80, 32'h80, 1);
    run_txn(0, 32'h7F, 32'h7F, 0);
    run_txn(0, 32'h01, 32'h08, 0);
    run_txn(0, 32'h37, 32'h00, 0);
    run_txn(0, 32'h37, 32'hFF, 0);
    run_txn(0, 32'h13, 32'h55, 0);
    run_txn(1, 32'h01, 32'h08, 0);
    run_txn(1, 32'hFF, 32'h08, 2);

    // Consumer stall with competing operands offered throughout.
    e = ref_model(0, 32'h18, 32'h28);
    sbq[0].push_back(e);
    send_rdy[0] = 1'b0;
    recv_val[0] = 1'b1;
    recv_msg[0] = pack(0, 32'h18, 32'h28);
    @(posedge clk);
    #1;
    recv_msg[0] = pack(0, 32'h7F, 32'h7F);
    wait_send(0, lat);
    chk("stall_latency", 64'(lat), 64'(e.lat));
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("stall_ctl c%0d", c), {62'd0, send_val[0], recv_rdy[0]}, 64'd2);
      chk($sformatf("stall_msg c%0d", c), {32'd0, send_msg[0]}, {32'd0, e.msg});
      @(posedge clk);
      #1;
    end
    recv_val[0] = 1'b0;
    send_rdy[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_release", {62'd0, recv_rdy[0], send_val[0]}, 64'd2);
    run_txn(0, 32'h7F, 32'h01, 0);

    // Reset during the second CALC cycle drops the transaction.
    recv_val[0] = 1'b1;
    recv_msg[0] = pack(0, 32'h18, 32'h28);
    @(posedge clk);
    #1;
    recv_val[0] = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("midrst_ctl", {62'd0, recv_rdy[0], send_val[0]}, 64'd2);
    chk("midrst_out", {31'd0, send_ovf[0], send_msg[0]}, 64'd0);
    run_txn(0, 32'h18, 32'h28, 0);

    for (int i = 0; i < NI; i++) begin
      msk = (NP[i] == 32) ? 32'hFFFF_FFFF : ((32'd1 << NP[i]) - 32'd1);
      for (int t = 0; t < 40; t++) begin
        a = $urandom & msk;
        b = $urandom & msk;
        b = b & 32'((64'd1 << $urandom_range(0, NP[i])) - 64'd1);
        if ($urandom_range(0, 1) == 1) b = (-b) & msk;
        case ($urandom_range(0, 7))
          0: a = 32'd1 << (NP[i]-1);
          1: b = 32'd1 << (NP[i]-1);
          2: b = 32'd0;
          3: a = msk >> 1;
          default: ;
        endcase
        run_txn(i, a, b, $urandom_range(0, 2));
      end
    end

    for (int i = 0; i < NI; i++) chk($sformatf("queue_drained[%0d]", i), 64'(sbq[i].size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fpmult_multibit.md
FPMULT_MULTIBIT -- requirements
Module: fpmult_multibit

Interface
REQ-001 Parameter n, default 32: operand and result width, two's-complement fixed point.
REQ-002 Parameter d, default 16: fractional bits, 0 <= d < n.
REQ-003 Parameter k, default 2: multiplier bits retired per CALC cycle; k SHALL divide n.
REQ-004 Parameter ROUND, default 0: 0 = truncate magnitude; 1 = round half away from zero.
REQ-005 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 recv_val, input, 1: operand pair valid.
REQ-008 recv_rdy, output, 1: block can accept an operand pair.
REQ-009 recv_msg, input, 2n: a = [2n-1:n], b = [n-1:0].
REQ-010 send_val, output, 1: result valid.
REQ-011 send_rdy, input, 1: consumer accepts result.
REQ-012 send_msg, output, n: saturated fixed-point product c = a*b.
REQ-013 send_ovf, output, 1: result was saturated; valid while send_val = 1.

Function
REQ-014 States: IDLE, CALC, FIN, DONE; one transaction in flight; no overlap of accept and send.
REQ-015 IDLE: recv_rdy = 1, send_val = 0. When recv_val = 1, latch |a|, |b| (n-bit unsigned), sign = a[n-1] XOR b[n-1], clear the 2n-bit accumulator and iteration counter; next state CALC.
REQ-016 CALC: accumulator += (|a| << k*count) * (k LSBs of the remaining |b|); remaining |b| >>= k; count += 1; recv_rdy = 0.
REQ-017 Leave CALC for FIN when count reaches n/k, or early when the post-shift remaining |b| is zero.
REQ-018 FIN, one cycle: compute and register send_msg and send_ovf; next state DONE.
REQ-019 Magnitude M = accumulator >> d; with ROUND = 1, M = (accumulator + 2^(d-1)) >> d. No rounding increment applies when d = 0.
REQ-020 Positive sign: if M > 2^(n-1)-1, then c = 2^(n-1)-1 and ovf = 1. Negative sign: if M > 2^(n-1), then c = -2^(n-1) and ovf = 1. Otherwise c = ±M and ovf = 0. A zero product is +0.
REQ-021 DONE: send_val = 1. send_msg and send_ovf stay stable until the handshake. On send_rdy = 1, next state IDLE.
REQ-022 Latency, measured from the accept edge to the first send_val cycle: (CALC cycles) + 1. CALC cycles lie in [1, n/k]. Minimum is 2, maximum is n/k + 1.
REQ-023 recv_val while not in IDLE is ignored; recv_msg is sampled only at the accept edge.
REQ-024 Operand -2^(n-1) SHALL be handled exactly; the magnitude 2^(n-1) fits in n unsigned bits.

Reset
REQ-025 Reset dominates all other inputs in any state, including mid-CALC and DONE; the in-flight transaction is discarded.
REQ-026 After the reset edge: state IDLE, recv_rdy = 1, send_val = 0, send_msg = 0, send_ovf = 0, accumulator = 0, counter = 0.

Structure
REQ-027 Package fpmult_pkg SHALL hold the state enum type (IDLE/CALC/FIN/DONE) and the ROUND mode constants.
REQ-028 Sub-module fpmult_round_sat (combinational, parameters n, d, ROUND) SHALL implement REQ-019/020; the FSM, counter, accumulator and operand registers stay in fpmult_multibit.

Verification (n=8, d=4, k=2 unless noted)
REQ-029 a=0x18 (1.5), b=0x28 (2.5), ROUND=0 -> send_msg=0x3C (3.75), ovf=0. send_val appears 4 cycles after the accept edge: early exit after 3 CALC cycles.
REQ-030 a=0xE8 (-1.5), b=0x28 -> send_msg=0xC4 (-3.75), ovf=0. a=0x80, b=0x80 -> send_msg=0x7F, ovf=1. a=0x7F, b=0x7F -> send_msg=0x7F, ovf=1.
REQ-031 a=0x01, b=0x08: ROUND=0 -> 0x00. ROUND=1 -> 0x01. With ROUND=1, a=0xFF, b=0x08 -> 0xFF.
REQ-032 b=0x00, any a -> send_msg=0x00 with send_val 2 cycles after accept. b=0xFF (|b|=1) -> send_val 2 cycles after accept. b=0x55 -> 4 CALC cycles, latency 5.
REQ-033 Hold send_rdy=0 for 5 cycles in DONE while driving new recv_val/recv_msg -> send_msg stable, recv_rdy=0, new operands not accepted. Release -> IDLE next cycle, then accept.
REQ-034 Assert reset during the 2nd CALC cycle -> next cycle IDLE, recv_rdy=1, send_val=0. The next transaction a=0x18, b=0x28 returns 0x3C. Random signed sweep vs. golden model for (n,d,k) = (8,4,2), (16,8,4), (32,16,1), including d=0.
